// File: rtl/urcpu_pkg.sv
// Shared URCPU datapath definitions: the common data width and the
// multiplier control-state encoding.
package urcpu_pkg;

    localparam int DATA_WIDTH = 20;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

endpackage

// File: rtl/adder.sv
// Generic ripple/carry adder of the URCPU datapath: {carry_out, sum} = a + b + carry_in.
module adder #(
    parameter int DATA_WIDTH = urcpu_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  carry_in,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + (DATA_WIDTH + 1)'(carry_in);

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-add multiplier with start/busy/done handshake.
// Define SEQ_MUL_EARLY_TERM_EN to finish as soon as no multiplier bits remain.
module seq_multiplier #(
    parameter int DATA_WIDTH = urcpu_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   multiplicand,
    input  logic [DATA_WIDTH-1:0]   multiplier,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product
);

    import urcpu_pkg::mul_state_t;
    import urcpu_pkg::IDLE;
    import urcpu_pkg::RUN;
    import urcpu_pkg::DONE;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    mul_state_t state_q, state_d;

    logic [2*DATA_WIDTH-1:0] prod;
    logic [2*DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0]   mq;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [2*DATA_WIDTH-1:0] sum;
    logic [2*DATA_WIDTH-1:0] prod_next;
    logic                    carry_unused;
    logic                    last_iter;
    logic                    zero_start;

    adder #(
        .DATA_WIDTH (2 * DATA_WIDTH)
    ) u_adder (
        .a         (prod),
        .b         (mcand),
        .carry_in  (1'b0),
        .sum       (sum),
        .carry_out (carry_unused)
    );

    assign prod_next = mq[0] ? sum : prod;

`ifdef SEQ_MUL_EARLY_TERM_EN
    // The multiplier bit being consumed now is the last set one.
    assign last_iter  = (cnt == LAST_CNT) || (mq[DATA_WIDTH-1:1] == '0);
    assign zero_start = (multiplier == '0);
`else
    assign last_iter  = (cnt == LAST_CNT);
    assign zero_start = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = zero_start ? DONE : RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod    <= '0;
            mcand   <= '0;
            mq      <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand <= {{DATA_WIDTH{1'b0}}, multiplicand};
                        mq    <= multiplier;
                        prod  <= '0;
                        cnt   <= '0;
                        if (zero_start) product <= '0;
                    end
                end
                RUN: begin
                    prod  <= prod_next;
                    mcand <= mcand << 1;
                    mq    <= mq >> 1;
                    cnt   <= cnt + CNT_WIDTH'(1);
                    // Publish the result only on entry to DONE.
                    if (last_iter) product <= prod_next;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: randomized and directed operations
// scored against an arithmetic reference model through an expectation queue.
module tb_seq_multiplier;

    localparam int W = 20;
    localparam logic [W-1:0] MASK = '1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    typedef struct {
        logic [2*W-1:0] prod;
        int             acc;
        int             lat;
    } exp_t;

    exp_t           sb[$];
    int             checks = 0;
    int             failures = 0;
    int             cyc = 0;
    logic [2*W-1:0] last_product = '0;

    seq_multiplier u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Number of RUN cycles between the accept edge and the done cycle.
    function automatic int exp_latency(input logic [W-1:0] m);
`ifdef SEQ_MUL_EARLY_TERM_EN
        int top;
        top = 0;
        if (m == '0) return 0;
        for (int i = 0; i < W; i++) if (m[i]) top = i;
        return top + 1;
`else
        return W;
`endif
    endfunction

    function automatic exp_t make_exp(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t e;
        e.prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.acc  = acc;
        e.lat  = exp_latency(b);
        return e;
    endfunction

    // Monitor: compares handshake and product against the head expectation.
    always @(negedge clk) begin
        bit exp_done;
        bit exp_busy;
        if (rst_n) begin
            exp_done = (sb.size() != 0) && ((cyc - sb[0].acc) == sb[0].lat);
            exp_busy = (sb.size() != 0) && ((cyc - sb[0].acc) < sb[0].lat);
            check("busy", 64'(busy), 64'(exp_busy));
            check("done", 64'(done), 64'(exp_done));
            if (exp_done) begin
                check("product", 64'(product), 64'(sb[0].prod));
                last_product = sb[0].prod;
                void'(sb.pop_front());
            end else begin
                check("product_hold", 64'(product), 64'(last_product));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        sb.push_back(make_exp(a, b, cyc));
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_pending", 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;

        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(20'd3, 20'd5);
        wait_idle();
        issue(20'hFFFFF, 20'hFFFFF);
        wait_idle();

        // Start pulse while busy must be ignored.
        issue(20'd0, 20'h12345);
        repeat (4) @(negedge clk);
        start        = 1'b1;
        multiplicand = 20'd2;
        multiplier   = 20'd2;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        issue(20'd9, 20'd0);
        wait_idle();

        // Held start: the next operation is accepted two edges after done.
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 20'd6;
        multiplier   = 20'd7;
        @(posedge clk);
        #1;
        sb.push_back(make_exp(20'd6, 20'd7, cyc));
        lat          = exp_latency(20'd7);
        multiplicand = 20'd11;
        multiplier   = 20'd13;
        repeat (lat + 2) @(posedge clk);
        #1;
        sb.push_back(make_exp(20'd11, 20'd13, cyc));
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-operation.
        issue(20'd7, 20'd9);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        last_product = '0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", 64'(product), 64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom) & MASK;
            b = (W'($urandom) & MASK) >> $urandom_range(0, W - 1);
            issue(a, b);
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
